// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: per-lane 8-bit parallel-to-serial converter.
// Sends one byte every 8 clk_32f cycles on a 1-bit registered lane output.
// Idle/comma symbol whenever no valid data; SYNC preamble after reset and
// after lane deactivation.
// Optional macro PS_LSB_FIRST_EN: serialise LSB-first instead of MSB-first.
module paralelo_serial_tx #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       lane_active,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       data_out,
    output logic       load_ack,
    output logic       sync_done
);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic [3:0] sync_cnt_nxt;
    logic [7:0] hold;
    logic [7:0] sel;
    logic       sample;

    // First bit of a freshly selected byte, driven on the sampling edge.
    function automatic logic first_bit(input logic [7:0] b);
`ifdef PS_LSB_FIRST_EN
        return b[0];
`else
        return b[7];
`endif
    endfunction

    // Bit of the held byte for the current position within the frame.
    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] pos);
`ifdef PS_LSB_FIRST_EN
        return b[pos];
`else
        return b[3'd7 - pos];
`endif
    endfunction

    assign sample = (bit_cnt == 3'd0);

    // State register: FSM advances only on frame boundaries.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            sync_cnt <= 4'd0;
        end else if (sample) begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
        end
    end

    // Next-state logic and byte selection for the upcoming frame.
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        sel          = IDLE_SYM;
        case (state)
            SYNC: begin
                if (!lane_active) begin
                    // Preamble restarts until the lane is enabled.
                    sync_cnt_nxt = 4'd0;
                end else if (sync_cnt == SYNC_LAST) begin
                    state_nxt    = ACTIVE;
                    sync_cnt_nxt = 4'd0;
                end else begin
                    sync_cnt_nxt = sync_cnt + 4'd1;
                end
            end
            ACTIVE: begin
                if (lane_active && valid_in) begin
                    sel = data_in;
                end
                if (!lane_active) begin
                    // The byte loaded on this edge is already idle.
                    state_nxt    = SYNC;
                    sync_cnt_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt    = SYNC;
                sync_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Datapath: bit counter, byte hold register and serial output.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            hold      <= 8'h00;
            data_out  <= 1'b0;
            load_ack  <= 1'b0;
            sync_done <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (sample) begin
                hold      <= sel;
                data_out  <= first_bit(sel);
                load_ack  <= 1'b1;
                sync_done <= (state_nxt == ACTIVE);
            end else begin
                data_out <= pick_bit(hold, bit_cnt);
                load_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx (SYNC_COUNT=4, IDLE_SYM=8'hBC).
// Honours PS_LSB_FIRST_EN for the expected bit order.
module tb_paralelo_serial_tx;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       lane_active;
    logic       valid_in;
    logic [7:0] data_in;
    logic       data_out;
    logic       load_ack;
    logic       sync_done;

    int checks = 0;
    int errors = 0;

    paralelo_serial_tx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .lane_active (lane_active),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .load_ack    (load_ack),
        .sync_done   (sync_done)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    // One full frame; the first tick is the sampling edge. drop_at>0 clears
    // lane_active after that many edges of the frame.
    task automatic frame(input string tag, input logic [7:0] exp_byte,
                         input logic exp_sd, input int drop_at);
        logic eb;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef PS_LSB_FIRST_EN
            eb = exp_byte[i];
`else
            eb = exp_byte[7 - i];
`endif
            chk($sformatf("%s data_out bit%0d", tag, i), data_out, eb);
            chk($sformatf("%s load_ack bit%0d", tag, i), load_ack, (i == 0));
            if (i == 0 || i == 7)
                chk($sformatf("%s sync_done bit%0d", tag, i), sync_done, exp_sd);
            if (drop_at > 0 && i == drop_at - 1)
                lane_active = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b1;
        lane_active = 1'b1;
        valid_in    = 1'b0;
        data_in     = 8'h00;
        #2;
        chk("reset data_out", data_out, 1'b0);
        chk("reset load_ack", load_ack, 1'b0);
        chk("reset sync_done", sync_done, 1'b0);
        @(negedge clk_32f);
        reset = 1'b0;

        // SYNC preamble: sync_done set by the 4th sampling edge
        frame("sync1", 8'hBC, 1'b0, 0);
        frame("sync2", 8'hBC, 1'b0, 0);
        frame("sync3", 8'hBC, 1'b0, 0);
        frame("sync4", 8'hBC, 1'b1, 0);
        frame("idle5", 8'hBC, 1'b1, 0);

        // Single byte, then idle
        valid_in = 1'b1; data_in = 8'hA5;
        frame("A5", 8'hA5, 1'b1, 0);
        data_in = 8'h01;
        frame("01", 8'h01, 1'b1, 0);
        valid_in = 1'b0;
        frame("idle_after", 8'hBC, 1'b1, 0);

        // Back-to-back bytes
        valid_in = 1'b1; data_in = 8'h00;
        frame("b2b_00", 8'h00, 1'b1, 0);
        data_in = 8'hFF;
        frame("b2b_FF", 8'hFF, 1'b1, 0);
        data_in = 8'h3C;
        frame("b2b_3C", 8'h3C, 1'b1, 0);

        // Lane drop mid-frame: 5A completes, then idle and a new preamble
        data_in = 8'h5A;
        frame("drop_5A", 8'h5A, 1'b1, 3);
        data_in = 8'h77;
        frame("drop_idle", 8'hBC, 1'b0, 0);
        frame("inactive", 8'hBC, 1'b0, 0);
        lane_active = 1'b1;
        frame("resync1", 8'hBC, 1'b0, 0);
        frame("resync2", 8'hBC, 1'b0, 0);
        frame("resync3", 8'hBC, 1'b0, 0);
        frame("resync4", 8'hBC, 1'b1, 0);
        frame("data_77", 8'h77, 1'b1, 0);

        // Reset in the middle of an all-ones frame
        data_in = 8'hFF;
        tick(); tick(); tick();
        chk("pre_reset data_out", data_out, 1'b1);
        chk("pre_reset sync_done", sync_done, 1'b1);
        reset = 1'b1;
        #1;
        chk("async data_out", data_out, 1'b0);
        chk("async load_ack", load_ack, 1'b0);
        chk("async sync_done", sync_done, 1'b0);
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        frame("rst_sync1", 8'hBC, 1'b0, 0);
        frame("rst_sync2", 8'hBC, 1'b0, 0);
        frame("rst_sync3", 8'hBC, 1'b0, 0);
        frame("rst_sync4", 8'hBC, 1'b1, 0);
        frame("rst_FF", 8'hFF, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
